// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: state enum, MIPS opcode
// and funct values, and the datapath select encodings driven by the decoder.
package control_pkg;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC1  = 3'd3,
        S_EXEC2  = 3'd4,
        S_STALL  = 3'd5
    } state_t;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    // ALU operation select
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_XOR   = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;
    localparam logic [2:0] ALU_SLTU  = 3'b111;

    // Write register select
    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    // Write data select
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_MEM  = 2'b01;
    localparam logic [1:0] RS_PC8  = 2'b10;
    localparam logic [1:0] RS_HILO = 2'b11;

    // True for the four R-type functs that run on the multi-cycle mul/div unit.
    function automatic logic is_muldiv_funct(input logic [5:0] fn);
        return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps opcode/funct onto the datapath
// constant controls and the class flags that the sequencer uses to decide
// how long each execute phase lasts and which write strobe to fire.
// Anything not recognised decodes to all-zero, which the sequencer runs as a NOP.
module instr_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] aluop,
    output logic       alusrc,
    output logic       extsel,
    output logic       lui,
    output logic       jump,
    output logic       jumpreg,
    output logic       branch,
    output logic       branch_ne,
    output logic [1:0] regdst,
    output logic [1:0] regsrc,
    output logic       is_load,
    output logic       is_store,
    output logic       is_muldiv,
    output logic       writes_reg,
    output logic       writes_hilo
);

    // Opcode/funct table; every output starts at zero so unknown encodings are NOPs.
    always_comb begin
        aluop       = ALU_ADD;
        alusrc      = 1'b0;
        extsel      = 1'b0;
        lui         = 1'b0;
        jump        = 1'b0;
        jumpreg     = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        regdst      = RD_RT;
        regsrc      = RS_ALU;
        is_load     = 1'b0;
        is_store    = 1'b0;
        is_muldiv   = 1'b0;
        writes_reg  = 1'b0;
        writes_hilo = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
                        aluop      = ALU_FUNCT;
                        regdst     = RD_RD;
                        writes_reg = 1'b1;
                    end
                    FN_JR: begin
                        aluop   = ALU_FUNCT;
                        jumpreg = 1'b1;
                    end
                    FN_JALR: begin
                        aluop      = ALU_FUNCT;
                        jumpreg    = 1'b1;
                        regdst     = RD_RD;
                        regsrc     = RS_PC8;
                        writes_reg = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        aluop      = ALU_FUNCT;
                        regdst     = RD_RD;
                        regsrc     = RS_HILO;
                        writes_reg = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        aluop       = ALU_FUNCT;
                        writes_hilo = 1'b1;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        aluop       = ALU_FUNCT;
                        is_muldiv   = is_muldiv_funct(funct);
                        writes_hilo = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_J: begin
                jump = 1'b1;
            end
            OP_JAL: begin
                jump       = 1'b1;
                regdst     = RD_RA;
                regsrc     = RS_PC8;
                writes_reg = 1'b1;
            end
            OP_BEQ: begin
                aluop  = ALU_SUB;
                extsel = 1'b1;
                branch = 1'b1;
            end
            OP_BNE: begin
                aluop     = ALU_SUB;
                extsel    = 1'b1;
                branch    = 1'b1;
                branch_ne = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                aluop      = ALU_ADD;
                alusrc     = 1'b1;
                extsel     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SLTI: begin
                aluop      = ALU_SLT;
                alusrc     = 1'b1;
                extsel     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SLTIU: begin
                // sltiu still sign-extends; only the compare is unsigned
                aluop      = ALU_SLTU;
                alusrc     = 1'b1;
                extsel     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_ANDI: begin
                aluop      = ALU_AND;
                alusrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_ORI: begin
                aluop      = ALU_OR;
                alusrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_XORI: begin
                aluop      = ALU_XOR;
                alusrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_LUI: begin
                lui        = 1'b1;
                alusrc     = 1'b1;
                writes_reg = 1'b1;
            end
            OP_LW: begin
                aluop      = ALU_ADD;
                alusrc     = 1'b1;
                extsel     = 1'b1;
                regsrc     = RS_MEM;
                is_load    = 1'b1;
                writes_reg = 1'b1;
            end
            OP_SW: begin
                aluop    = ALU_ADD;
                alusrc   = 1'b1;
                extsel   = 1'b1;
                is_store = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle sequencer: FETCH -> DECODE -> EXEC1 -> (STALL) -> EXEC2, with a
// terminal HALT entered when the committing instruction writes PC = 0.
// Bus-facing states (FETCH, lw EXEC1, sw EXEC2) hold while waitrequest is high.
// Decode constants are only presented while an instruction is executing;
// write/read strobes come purely from the current state and decode class.
module control_fsm
    import control_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       waitrequest,
    input  logic       pc_next_zero,
    output logic [2:0] state,
    output logic       active,
    output logic [2:0] ALUOp,
    output logic       ALUSrc,
    output logic       extsel,
    output logic       lui,
    output logic       jump,
    output logic       jumpreg,
    output logic       branch,
    output logic       branch_ne,
    output logic       memread,
    output logic       memwrite,
    output logic       inwrite,
    output logic       pctoadd,
    output logic       pcwrite,
    output logic [1:0] regdst,
    output logic [1:0] regsrc,
    output logic       regwrite,
    output logic       hilo_write,
    output logic       muldiv_start
);

    localparam int CW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CW-1:0] COUNT_LOAD = CW'(MULDIV_CYCLES - 1);

    state_t         cur_state;
    state_t         nxt_state;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           in_exec;

    logic [2:0] dec_aluop;
    logic       dec_alusrc;
    logic       dec_extsel;
    logic       dec_lui;
    logic       dec_jump;
    logic       dec_jumpreg;
    logic       dec_branch;
    logic       dec_branch_ne;
    logic [1:0] dec_regdst;
    logic [1:0] dec_regsrc;
    logic       dec_is_load;
    logic       dec_is_store;
    logic       dec_is_muldiv;
    logic       dec_writes_reg;
    logic       dec_writes_hilo;

    instr_decode u_decode (
        .opcode      (opcode),
        .funct       (funct),
        .aluop       (dec_aluop),
        .alusrc      (dec_alusrc),
        .extsel      (dec_extsel),
        .lui         (dec_lui),
        .jump        (dec_jump),
        .jumpreg     (dec_jumpreg),
        .branch      (dec_branch),
        .branch_ne   (dec_branch_ne),
        .regdst      (dec_regdst),
        .regsrc      (dec_regsrc),
        .is_load     (dec_is_load),
        .is_store    (dec_is_store),
        .is_muldiv   (dec_is_muldiv),
        .writes_reg  (dec_writes_reg),
        .writes_hilo (dec_writes_hilo)
    );

    assign state = cur_state;

    // State register and mul/div stall counter; reset lands directly in FETCH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_state <= S_FETCH;
            count     <= '0;
        end else begin
            cur_state <= nxt_state;
            count     <= count_next;
        end
    end

    assign in_exec = (cur_state == S_EXEC1) || (cur_state == S_EXEC2) ||
                     (cur_state == S_STALL);

    // Decode constants pass through only while an instruction is executing.
    always_comb begin
        ALUOp     = ALU_ADD;
        ALUSrc    = 1'b0;
        extsel    = 1'b0;
        lui       = 1'b0;
        jump      = 1'b0;
        jumpreg   = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        regdst    = RD_RT;
        regsrc    = RS_ALU;
        if (in_exec) begin
            ALUOp     = dec_aluop;
            ALUSrc    = dec_alusrc;
            extsel    = dec_extsel;
            lui       = dec_lui;
            jump      = dec_jump;
            jumpreg   = dec_jumpreg;
            branch    = dec_branch;
            branch_ne = dec_branch_ne;
            regdst    = dec_regdst;
            regsrc    = dec_regsrc;
        end
    end

    // Next-state, counter and strobe generation.
    always_comb begin
        nxt_state    = cur_state;
        count_next   = count;
        active       = 1'b1;
        memread      = 1'b0;
        memwrite     = 1'b0;
        inwrite      = 1'b0;
        pctoadd      = 1'b0;
        pcwrite      = 1'b0;
        regwrite     = 1'b0;
        hilo_write   = 1'b0;
        muldiv_start = 1'b0;

        case (cur_state)
            S_HALT: begin
                active    = 1'b0;
                nxt_state = S_HALT;
            end
            S_FETCH: begin
                memread = 1'b1;
                pctoadd = 1'b1;
                if (!waitrequest) begin
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                inwrite   = 1'b1;
                pctoadd   = 1'b1;
                nxt_state = S_EXEC1;
            end
            S_EXEC1: begin
                if (dec_is_load) begin
                    memread = 1'b1;
                    if (!waitrequest) begin
                        nxt_state = S_EXEC2;
                    end
                end else if (dec_is_muldiv) begin
                    muldiv_start = 1'b1;
                    count_next   = COUNT_LOAD;
                    nxt_state    = S_STALL;
                end else begin
                    nxt_state = S_EXEC2;
                end
            end
            S_STALL: begin
                // The counter value on entry is the number of further stall cycles.
                if (count == '0) begin
                    nxt_state = S_EXEC2;
                end else begin
                    count_next = count - CW'(1);
                end
            end
            S_EXEC2: begin
                memwrite = dec_is_store;
                // Only a stalled store holds EXEC2; the commit happens on the
                // cycle the bus accepts it, so pcwrite and halt wait for that.
                if (!(dec_is_store && waitrequest)) begin
                    pcwrite    = 1'b1;
                    regwrite   = dec_writes_reg;
                    hilo_write = dec_writes_hilo;
                    nxt_state  = pc_next_zero ? S_HALT : S_FETCH;
                end
            end
            default: begin
                nxt_state = S_FETCH;
            end
        endcase
    end

endmodule
